// File: rtl/fd_hazard_if.sv
// Bundle between the EX/MEM stages and the fetch/decode hazard controller.
// The master drives the pipeline-side inputs; the slave is the controller.
interface fd_hazard_if #(
  parameter int PC_BITS  = 12,
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic [REG_BITS-1:0] D_rs1;
  logic [REG_BITS-1:0] D_rs2;
  logic                D_use_rs1;
  logic                D_use_rs2;
  logic [REG_BITS-1:0] EX_rd;
  logic                EX_is_load;
  logic                EX_taken;
  logic [PC_BITS-1:0]  EX_target_pc;
  logic                M_mem_req;
  logic                M_mem_ready;
  logic                stall_D;
  logic                MEM_stall;
  logic                flush_D;
  logic                flush_E;
  logic                F_redirect;
  logic [PC_BITS-1:0]  F_redirect_pc;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  modport master (
    output D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_is_load,
           EX_taken, EX_target_pc, M_mem_req, M_mem_ready,
    input  stall_D, MEM_stall, flush_D, flush_E, F_redirect, F_redirect_pc,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_is_load,
           EX_taken, EX_target_pc, M_mem_req, M_mem_ready,
    output stall_D, MEM_stall, flush_D, flush_E, F_redirect, F_redirect_pc,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fd_hazard_ctrl.sv
// Fetch/decode hazard controller: load-use stall, memory-wait freeze, EX redirect
// with hold-over across memory stalls, and saturating stall/flush event counters.
//
//  state | meaning
//  RUN   | no outstanding data-memory access
//  MWAIT | data access issued, waiting for M_mem_ready
module fd_hazard_ctrl #(
  parameter int PC_BITS  = 12,
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  fd_hazard_if.slave  bus
);

  typedef enum logic {RUN, MWAIT} state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [REG_BITS-1:0] REG_ZERO = '0;

  state_t              r_state;
  logic                r_pend;
  logic [PC_BITS-1:0]  r_pend_pc;
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic [CNT_BITS-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_luh;
  logic w_redirect;
  logic w_stall_d;
  logic w_flush_e;
  logic [PC_BITS-1:0] w_redirect_pc;

  // Every output is gated by rst_n so the combinational paths also read 0 in reset.
  always_comb begin
    w_mem_stall = rst_n & ((bus.M_mem_req & ~bus.M_mem_ready) |
                           ((r_state == MWAIT) & ~bus.M_mem_ready));
    w_luh       = bus.EX_is_load & (bus.EX_rd != REG_ZERO) &
                  ((bus.D_use_rs1 & (bus.D_rs1 == bus.EX_rd)) |
                   (bus.D_use_rs2 & (bus.D_rs2 == bus.EX_rd)));
    w_redirect  = rst_n & (bus.EX_taken | r_pend) & ~w_mem_stall;
    w_stall_d   = rst_n & w_luh & ~w_mem_stall & ~w_redirect;
    w_flush_e   = w_redirect | (rst_n & w_luh & ~w_mem_stall);
    w_redirect_pc = '0;
    if (rst_n)
      w_redirect_pc = bus.EX_taken ? bus.EX_target_pc : r_pend_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN:     if (bus.M_mem_req && !bus.M_mem_ready) r_state <= MWAIT;
        MWAIT:   if (bus.M_mem_ready)                   r_state <= RUN;
        default: r_state <= RUN;
      endcase

      // A fresh pulse during a stall replaces any target already held.
      if (bus.EX_taken && w_mem_stall) begin
        r_pend    <= 1'b1;
        r_pend_pc <= bus.EX_target_pc;
      end else if (w_redirect) begin
        r_pend    <= 1'b0;
      end

      if ((w_mem_stall || w_stall_d) && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_redirect && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign bus.MEM_stall     = w_mem_stall;
  assign bus.stall_D       = w_stall_d;
  assign bus.flush_D       = w_redirect;
  assign bus.flush_E       = w_flush_e;
  assign bus.F_redirect    = w_redirect;
  assign bus.F_redirect_pc = w_redirect_pc;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_fd_hazard_ctrl.sv
// Directed bench for fd_hazard_ctrl: hand-computed vectors for hazards, redirects,
// memory waits, reset gating, and counter saturation on a 4-bit-counter instance.
module tb_fd_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fd_hazard_if #(.PC_BITS(12), .REG_BITS(5), .CNT_BITS(16)) m_if ();
  fd_hazard_if #(.PC_BITS(12), .REG_BITS(5), .CNT_BITS(4))  s_if ();

  fd_hazard_ctrl #(.PC_BITS(12), .REG_BITS(5), .CNT_BITS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  fd_hazard_ctrl #(.PC_BITS(12), .REG_BITS(5), .CNT_BITS(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_if.D_rs1 = '0; m_if.D_rs2 = '0; m_if.D_use_rs1 = 1'b0; m_if.D_use_rs2 = 1'b0;
    m_if.EX_rd = '0; m_if.EX_is_load = 1'b0; m_if.EX_taken = 1'b0;
    m_if.EX_target_pc = '0; m_if.M_mem_req = 1'b0; m_if.M_mem_ready = 1'b0;
  endtask

  task automatic set_luh(input logic on);
    m_if.EX_is_load = on; m_if.EX_rd = 5'd5; m_if.D_rs1 = 5'd5; m_if.D_use_rs1 = on;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    s_if.D_rs1 = '0; s_if.D_rs2 = '0; s_if.D_use_rs1 = 1'b0; s_if.D_use_rs2 = 1'b0;
    s_if.EX_rd = '0; s_if.EX_is_load = 1'b0; s_if.EX_taken = 1'b0;
    s_if.EX_target_pc = '0; s_if.M_mem_req = 1'b0; s_if.M_mem_ready = 1'b0;

    // Reset with active inputs: combinational outputs must still read 0.
    rst_n = 1'b0;
    m_if.EX_taken = 1'b1; m_if.EX_target_pc = 12'h3C3; m_if.M_mem_req = 1'b1;
    set_luh(1'b1);
    #2;
    chk("rst_mem_stall", m_if.MEM_stall, 0);
    chk("rst_redirect",  m_if.F_redirect, 0);
    chk("rst_pc",        m_if.F_redirect_pc, 0);
    chk("rst_flush_e",   m_if.flush_E, 0);
    chk("rst_stall_d",   m_if.stall_D, 0);
    tick();
    chk("rst_stall_cnt", m_if.stall_cnt, 0);
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();

    // Load-use on rs1
    set_luh(1'b1); #1;
    chk("luh_stall_d", m_if.stall_D, 1);
    chk("luh_flush_e", m_if.flush_E, 1);
    chk("luh_flush_d", m_if.flush_D, 0);
    chk("luh_memst",   m_if.MEM_stall, 0);
    tick();                                   // stall_cnt 1
    m_if.EX_is_load = 1'b0; #1;
    chk("luh_gone", m_if.stall_D, 0);
    chk("luh_cnt1", m_if.stall_cnt, 1);
    m_if.EX_is_load = 1'b1; m_if.EX_rd = 5'd0; m_if.D_rs1 = 5'd0; #1;
    chk("luh_rd0_stall", m_if.stall_D, 0);
    chk("luh_rd0_flush", m_if.flush_E, 0);
    m_if.EX_rd = 5'd9; m_if.D_rs1 = 5'd9; m_if.D_use_rs1 = 1'b0; #1;
    chk("luh_unused_rs1", m_if.stall_D, 0);
    m_if.D_rs1 = 5'd3; m_if.D_rs2 = 5'd9; m_if.D_use_rs2 = 1'b1; #1;
    chk("luh_rs2", m_if.stall_D, 1);
    tick();                                   // stall_cnt 2
    idle_inputs();

    // Memory wait with a redirect arriving mid-wait
    m_if.M_mem_req = 1'b1; #1;
    chk("mw1_stall", m_if.MEM_stall, 1);
    tick();                                   // 3, MWAIT
    m_if.EX_taken = 1'b1; m_if.EX_target_pc = 12'h123; #1;
    chk("mw2_stall", m_if.MEM_stall, 1);
    chk("mw2_noredir", m_if.F_redirect, 0);
    chk("mw2_noflush", m_if.flush_D, 0);
    tick();                                   // 4, pending
    m_if.EX_taken = 1'b0; m_if.EX_target_pc = 12'h000; #1;
    chk("mw3_stall", m_if.MEM_stall, 1);
    chk("mw3_noredir", m_if.F_redirect, 0);
    tick();                                   // 5
    m_if.M_mem_ready = 1'b1; #1;
    chk("mw_done_stall", m_if.MEM_stall, 0);
    chk("pend_redir",    m_if.F_redirect, 1);
    chk("pend_pc",       m_if.F_redirect_pc, 12'h123);
    chk("pend_flush_d",  m_if.flush_D, 1);
    chk("pend_flush_e",  m_if.flush_E, 1);
    chk("mw_stall_cnt",  m_if.stall_cnt, 5);
    tick();
    idle_inputs(); #1;
    chk("pend_cleared", m_if.F_redirect, 0);
    chk("back_to_run",  m_if.MEM_stall, 0);
    chk("flush_cnt1",   m_if.flush_cnt, 1);

    // Redirect beats load-use
    m_if.EX_taken = 1'b1; m_if.EX_target_pc = 12'h040; set_luh(1'b1); #1;
    chk("rl_redir",   m_if.F_redirect, 1);
    chk("rl_pc",      m_if.F_redirect_pc, 12'h040);
    chk("rl_stall_d", m_if.stall_D, 0);
    chk("rl_flush_d", m_if.flush_D, 1);
    chk("rl_flush_e", m_if.flush_E, 1);
    tick();
    idle_inputs(); #1;
    chk("flush_cnt2", m_if.flush_cnt, 2);
    chk("stall_cnt5", m_if.stall_cnt, 5);

    // Two pulses during one wait: the last target wins; luh masked by MEM_stall
    m_if.M_mem_req = 1'b1; m_if.EX_taken = 1'b1; m_if.EX_target_pc = 12'h0AA;
    tick();                                   // 6
    m_if.EX_target_pc = 12'h0BB; set_luh(1'b1); #1;
    chk("ms_luh_stall_d", m_if.stall_D, 0);
    chk("ms_luh_flush_e", m_if.flush_E, 0);
    tick();                                   // 7
    idle_inputs(); m_if.M_mem_ready = 1'b1; #1;
    chk("lastwin_redir", m_if.F_redirect, 1);
    chk("lastwin_pc",    m_if.F_redirect_pc, 12'h0BB);
    tick();
    idle_inputs(); #1;
    chk("flush_cnt3", m_if.flush_cnt, 3);
    chk("stall_cnt7", m_if.stall_cnt, 7);

    // Saturation on the 4-bit instance
    chk("sat_start", s_if.stall_cnt, 0);
    s_if.M_mem_req = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", s_if.stall_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_held", s_if.stall_cnt, 15);
    chk("sat_still_stall", s_if.MEM_stall, 1);
    s_if.M_mem_req = 1'b0;
    chk("main_idle_cnt", m_if.stall_cnt, 7);

    // Reset mid-wait with a pending redirect
    m_if.M_mem_req = 1'b1;
    tick();
    m_if.EX_taken = 1'b1; m_if.EX_target_pc = 12'h155;
    tick();
    m_if.EX_taken = 1'b0; #1;
    chk("pre_rst_pend", m_if.F_redirect, 0);
    rst_n = 1'b0; #1;
    chk("mid_rst_stall", m_if.MEM_stall, 0);
    chk("mid_rst_pc",    m_if.F_redirect_pc, 0);
    chk("mid_rst_scnt",  m_if.stall_cnt, 0);
    chk("mid_rst_fcnt",  m_if.flush_cnt, 0);
    idle_inputs();
    tick();
    rst_n = 1'b1; #1;
    chk("post_rst_redir", m_if.F_redirect, 0);
    chk("post_rst_stall", m_if.MEM_stall, 0);
    tick();
    chk("post_rst_fcnt", m_if.flush_cnt, 0);
    chk("post_rst_scnt", m_if.stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
